// File: rtl/regfile_wb.sv
// regfile_wb: 8x16 register file (R0 = 0) with registered A/B operand latches and a write-ack pulse.
// Define REGFILE_WB_BYPASS_EN to forward a same-edge writeback into the operand latches.
module regfile_wb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              wb_ack
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, rd_a, rd_b;
  logic              ack_q, ack_d, wr;
  assign wr = wb_en & (wb_addr != '0);
  always_comb begin
    regs_d = regs_q;
    if (wr) regs_d[wb_addr] = wb_data;
    rd_a = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
    rd_b = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
`ifdef REGFILE_WB_BYPASS_EN
    rd_a = (wr && wb_addr == rs1_addr) ? wb_data : rd_a;
    rd_b = (wr && wb_addr == rs2_addr) ? wb_data : rd_b;
`endif
    a_d   = rd_en ? rd_a : a_q;
    b_d   = rd_en ? rd_b : b_q;
    ack_d = wr;
  end
  // R0 is never written, so it stays at its reset value of zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      a_q   <= '0;
      b_q   <= '0;
      ack_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      a_q    <= a_d;
      b_q    <= b_d;
      ack_q  <= ack_d;
    end
  end
  assign a_out  = a_q;
  assign b_out  = b_q;
  assign wb_ack = ack_q;
endmodule
